// File: rtl/ysyx_24080014_isram.sv
// Read-only instruction SRAM slave for the IFU: one AR accepted at a time, and
// the word is returned on R after a fixed or LFSR-randomised wait.
module ysyx_24080014_isram #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter bit          LAT_MODE   = 1'b0,
  parameter int          FIX_LAT    = 0,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter              INIT_FILE  = "inst.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  lat_load;
  logic [7:0]  lfsr;
  logic [31:0] addr_q;
  logic [31:0] off;
  logic [31:0] dec_data;
  logic [1:0]  dec_resp;

  // The image is placed here by the environment (loader or bench preload).
  logic [31:0] mem [DEPTH] = '{default: '0};

  assign lat_load = LAT_MODE ? {2'b00, lfsr[1:0]} : 4'(FIX_LAT);
  assign off      = addr_q - BASE_ADDR;

  // Misalignment is checked first; BASE_ADDR is word aligned, so off[1:0] == addr_q[1:0].
  always_comb begin
    dec_data = '0;
    dec_resp = 2'b00;
    if (off[1:0] != 2'b00) begin
      dec_resp = 2'b10;
    end else if ((addr_q < BASE_ADDR) || (off[31:DEPTH_LOG2+2] != '0)) begin
      dec_resp = 2'b11;
    end else begin
      dec_data = mem[off[DEPTH_LOG2+1:2]];
    end
  end

  // Fibonacci taps 8,6,5,4; a non-zero seed keeps it out of the all-zero lockup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid && arready) begin
            addr_q  <= araddr;
            cnt     <= lat_load;
            arready <= 1'b0;
            state   <= WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rdata  <= dec_data;
            rresp  <= dec_resp;
            rvalid <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_isram.sv
// Bench for ysyx_24080014_isram: three instances (fixed 0, fixed 3, random latency)
// sharing clock and reset, driven by a vector table and directed sequences.
module tb_ysyx_24080014_isram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        arvalid [3];
  logic        arready [3];
  logic [31:0] araddr  [3];
  logic        rvalid  [3];
  logic        rready  [3];
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];

  int checks = 0;
  int errors = 0;
  int rcount = 0;
  logic [7:0] lfsr_m;

  ysyx_24080014_isram #(.LAT_MODE(1'b0), .FIX_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]),
    .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .rresp(rresp[0]));
  ysyx_24080014_isram #(.LAT_MODE(1'b0), .FIX_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]),
    .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .rresp(rresp[1]));
  ysyx_24080014_isram #(.LAT_MODE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .arvalid(arvalid[2]), .arready(arready[2]), .araddr(araddr[2]),
    .rvalid(rvalid[2]), .rready(rready[2]), .rdata(rdata[2]), .rresp(rresp[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5, steps every clock out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  always @(posedge clk) begin
    if (!rst && rvalid[2] && rready[2]) rcount <= rcount + 1;
  end

  function automatic logic [31:0] img(input int i);
    return 32'h0000_0413 + (32'(i) << 12);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One complete read with rready held high; lat counts edges from the AR handshake
  // edge to the edge that completes the R handshake (fixed mode: FIX_LAT + 2).
  task automatic rd(input int k, input logic [31:0] a, output logic [31:0] d,
                    output logic [1:0] r, output int lat, output logic [7:0] lf);
    int n;
    @(negedge clk);
    arvalid[k] = 1'b1;
    araddr[k]  = a;
    rready[k]  = 1'b1;
    n = 0;
    while (!arready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("arready_seen", 32'(arready[k]), 32'd1);
    lf = lfsr_m;
    @(negedge clk);
    arvalid[k] = 1'b0;
    araddr[k]  = ~a;
    lat = 1;
    while (!rvalid[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("rvalid_seen", 32'(rvalid[k]), 32'd1);
    d = rdata[k];
    r = rresp[k];
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic [7:0]  lf;

    vecs[0] = '{BASE,                img(0),    2'b00};
    vecs[1] = '{BASE + 32'h4,        img(1),    2'b00};
    vecs[2] = '{BASE + 32'h3FFC,     img(4095), 2'b00};
    vecs[3] = '{BASE + 32'h4000,     32'h0,     2'b11};
    vecs[4] = '{BASE + 32'h2,        32'h0,     2'b10};
    vecs[5] = '{BASE + 32'h1,        32'h0,     2'b10};
    vecs[6] = '{32'h7FFF_FFFC,       32'h0,     2'b11};
    vecs[7] = '{32'h0000_0000,       32'h0,     2'b11};
    vecs[8] = '{32'hFFFF_FFFE,       32'h0,     2'b10};
    vecs[9] = '{BASE + 32'h100,      img(64),   2'b00};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      arvalid[k] = 1'b0;
      araddr[k]  = '0;
      rready[k]  = 1'b0;
    end
    #1;
    for (int i = 0; i < 4096; i++) begin
      dut0.mem[i] = img(i);
      dut1.mem[i] = img(i);
      dut2.mem[i] = img(i);
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_arready", 32'(arready[k]), 32'd0);
      chk("rst_rvalid",  32'(rvalid[k]),  32'd0);
      chk("rst_rdata",   rdata[k],        32'd0);
      chk("rst_rresp",   32'(rresp[k]),   32'd0);
    end

    // Reset release with an AR already pending on the zero-latency instance.
    arvalid[0] = 1'b1;
    araddr[0]  = BASE;
    rready[0]  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rel_arready_before_edge", 32'(arready[0]), 32'd0);
    @(negedge clk);
    chk("rel_arready_edge0", 32'(arready[0]), 32'd1);
    chk("rel_rvalid_edge0",  32'(rvalid[0]),  32'd0);
    @(negedge clk);
    chk("rel_arready_edge1", 32'(arready[0]), 32'd0);
    chk("rel_rvalid_edge1",  32'(rvalid[0]),  32'd0);
    arvalid[0] = 1'b0;
    @(negedge clk);
    chk("rel_rvalid_edge2", 32'(rvalid[0]), 32'd1);
    chk("rel_rdata_edge2",  rdata[0],       32'h0000_0413);
    chk("rel_rresp_edge2",  32'(rresp[0]),  32'd0);
    @(negedge clk);
    chk("rel_rvalid_done",  32'(rvalid[0]),  32'd0);
    chk("rel_arready_done", 32'(arready[0]), 32'd1);

    // Vector table on the zero-latency instance.
    for (int i = 0; i < 10; i++) begin
      rd(0, vecs[i].addr, d, r, lat, lf);
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].data);
      chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
    end

    // FIX_LAT=3, rready low after rvalid, arvalid kept high with araddr toggling.
    @(negedge clk);
    arvalid[1] = 1'b1;
    araddr[1]  = BASE + 32'h8;
    rready[1]  = 1'b0;
    begin
      int n;
      n = 0;
      while (!arready[1] && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t2_arready_seen", 32'(arready[1]), 32'd1);
    end
    @(negedge clk);
    lat = 1;
    while (!rvalid[1] && lat < 50) begin
      chk("t2_arready_wait", 32'(arready[1]), 32'd0);
      araddr[1] = araddr[1] ^ 32'h10;
      @(negedge clk);
      lat++;
    end
    chk("t2_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_rvalid",  32'(rvalid[1]),  32'd1);
      chk("t2_hold_rdata",   rdata[1],        img(2));
      chk("t2_hold_rresp",   32'(rresp[1]),   32'd0);
      chk("t2_hold_arready", 32'(arready[1]), 32'd0);
      araddr[1] = araddr[1] ^ 32'h10;
      @(negedge clk);
    end
    arvalid[1] = 1'b0;
    rready[1]  = 1'b1;
    @(negedge clk);
    chk("t2_done_rvalid",  32'(rvalid[1]),  32'd0);
    chk("t2_done_arready", 32'(arready[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_no_dup_rvalid", 32'(rvalid[1]), 32'd0);
    end

    // Reset pulsed while the FIX_LAT=3 instance is in WAIT.
    arvalid[1] = 1'b1;
    araddr[1]  = BASE + 32'h20;
    @(negedge clk);
    arvalid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_rvalid",  32'(rvalid[1]),  32'd0);
    chk("t5_rst_arready", 32'(arready[1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_rst_hold_rvalid",  32'(rvalid[1]),  32'd0);
      chk("t5_rst_hold_arready", 32'(arready[1]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("t5_rel_arready_before", 32'(arready[1]), 32'd0);
    @(negedge clk);
    chk("t5_rel_arready", 32'(arready[1]), 32'd1);
    chk("t5_rel_rvalid",  32'(rvalid[1]),  32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_stale_rvalid", 32'(rvalid[1]), 32'd0);
    end
    rd(1, BASE + 32'hC, d, r, lat, lf);
    chk("t5_next_rdata", d,      img(3));
    chk("t5_next_rresp", 32'(r), 32'd0);
    chk("t5_next_lat",   32'(lat), 32'd5);

    // Random latency, 1000 back-to-back reads of a linear pc sequence.
    for (int i = 0; i < 1000; i++) begin
      rd(2, BASE + 32'(i) * 32'd4, d, r, lat, lf);
      chk("t6_rdata", d,      img(i));
      chk("t6_rresp", 32'(r), 32'd0);
      chk("t6_lat",   32'(lat), 32'(lf[1:0]) + 32'd2);
    end
    @(posedge clk);
    #1;
    chk("t6_resp_count", 32'(rcount), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
